// File: rtl/jtpopeye_pkg.sv
//------------------------------------------------------------------------------
// jtpopeye_pkg: shared encodings for the sprite DMA bus arbiter. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package jtpopeye_pkg;
   localparam int         OBJ_RAM_AW = 10;
   localparam logic [7:0] DD_IDLE    = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PEND    = 2'd1,
      ST_GRANT   = 2'd2,
      ST_RELEASE = 2'd3
   } arb_state_t;

   // What the DMA data output shows this clk, decided by the previous clk
   typedef enum logic [1:0] {
      RD_HOLD = 2'd0,
      RD_LIVE = 2'd1,
      RD_PULL = 2'd2
   } rd_mode_t;
endpackage

`default_nettype wire

// File: rtl/jtpopeye_objram.sv
//------------------------------------------------------------------------------
// jtpopeye_objram: single-port object RAM, synchronous write, registered read. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module jtpopeye_objram
   import jtpopeye_pkg::*;
#(
   parameter int AW = OBJ_RAM_AW
) (
   input  logic          clk,
   input  logic [AW-1:0] i_addr,
   input  logic          i_we,
   input  logic [7:0]    i_din,
   output logic [7:0]    o_q
);
   logic [7:0] r_mem [0:(1<<AW)-1];
   logic [7:0] r_q;

   // Read returns the pre-write contents when address and write collide
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_din;
      r_q <= r_mem[i_addr];
   end

   assign o_q = r_q;
endmodule

`default_nettype wire

// File: rtl/jtpopeye_busarb.sv
//------------------------------------------------------------------------------
// jtpopeye_busarb: Z80-side sprite DMA bus arbiter owning the object RAM. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module jtpopeye_busarb
   import jtpopeye_pkg::*;
#(
   parameter int          AW        = OBJ_RAM_AW,
   parameter logic [15:0] MAX_GRANT = 16'd640,
   parameter int          MIN_LAT   = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_cen,
   input  logic          busrq_n,
   output logic          busak_n,
   input  logic          cpu_mreq_n,
   input  logic          cpu_rd_n,
   input  logic          cpu_wr_n,
   input  logic          cpu_cs,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_dout,
   output logic [7:0]    cpu_din,
   output logic          cpu_busrq_n,
   input  logic [AW-1:0] AD_DMA,
   output logic [7:0]    DD_DMA,
   input  logic          dma_cs,
   output logic [15:0]   grant_len,
   output logic          overrun
);
   localparam logic [7:0] c_MIN_LAT = 8'(MIN_LAT);

   arb_state_t  r_state;
   logic        r_rq_s;
   logic [7:0]  r_lat_cnt;
   logic [15:0] r_gcnt;
   logic        r_busak_n;
   logic        r_cpu_busrq_n;
   logic [15:0] r_grant_len;
   logic        r_overrun;

   rd_mode_t    r_dd_mode;
   logic [7:0]  r_dd_last;
   logic        r_din_live;
   logic [7:0]  r_din_last;

   logic          w_grant;
   logic [7:0]    w_lat_nx;
   logic [15:0]   w_gcnt_nx;
   logic          w_cpu_we;
   logic          w_cpu_re;
   logic [AW-1:0] w_ram_addr;
   logic [7:0]    w_ram_q;
   logic [7:0]    w_dd;
   logic [7:0]    w_din;

   assign w_grant   = (r_state == ST_GRANT);
   assign w_lat_nx  = (&r_lat_cnt) ? r_lat_cnt : r_lat_cnt + 8'd1;
   assign w_gcnt_nx = (&r_gcnt)    ? r_gcnt    : r_gcnt + 16'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rq_s        <= 1'b1;
         r_state       <= ST_IDLE;
         r_lat_cnt     <= 8'd0;
         r_gcnt        <= 16'd0;
         r_busak_n     <= 1'b1;
         r_cpu_busrq_n <= 1'b1;
         r_grant_len   <= 16'd0;
         r_overrun     <= 1'b0;
      end else begin
         r_rq_s <= busrq_n;
         if (cpu_cen) begin
            case (r_state)
               ST_IDLE: begin
                  if (!r_rq_s) begin
                     r_state       <= ST_PEND;
                     r_cpu_busrq_n <= 1'b0;
                     r_lat_cnt     <= 8'd0;
                  end
               end
               ST_PEND: begin
                  r_lat_cnt <= w_lat_nx;
                  // A withdrawn request beats a qualifying grant on the same tick
                  if (r_rq_s) begin
                     r_state       <= ST_IDLE;
                     r_cpu_busrq_n <= 1'b1;
                  end else if (w_lat_nx >= c_MIN_LAT && cpu_mreq_n) begin
                     r_state   <= ST_GRANT;
                     r_busak_n <= 1'b0;
                     r_gcnt    <= 16'd0;
                  end
               end
               ST_GRANT: begin
                  r_gcnt <= w_gcnt_nx;
                  if (w_gcnt_nx >= MAX_GRANT) r_overrun <= 1'b1;
                  if (r_rq_s) r_state <= ST_RELEASE;
               end
               default: begin
                  r_busak_n     <= 1'b1;
                  r_cpu_busrq_n <= 1'b1;
                  r_grant_len   <= r_gcnt;
                  r_state       <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // The Z80 is locked out of the RAM port for the whole grant
   assign w_cpu_we   = !w_grant && cpu_cs && !cpu_mreq_n && !cpu_wr_n && cpu_cen;
   assign w_cpu_re   = !w_grant && cpu_cs && !cpu_rd_n && cpu_cen;
   assign w_ram_addr = w_grant ? AD_DMA : cpu_addr;

   jtpopeye_objram #(.AW(AW)) u_objram (
      .clk    (clk),
      .i_addr (w_ram_addr),
      .i_we   (w_cpu_we),
      .i_din  (cpu_dout),
      .o_q    (w_ram_q)
   );

   // The RAM output register doubles as the read data register of whichever
   // consumer loaded it last clk; the *_last copies hold value otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_dd_mode  <= RD_HOLD;
         r_dd_last  <= 8'd0;
         r_din_live <= 1'b0;
         r_din_last <= 8'd0;
      end else begin
         r_dd_last  <= w_dd;
         r_din_last <= w_din;
         r_din_live <= w_cpu_re;
         if (w_grant) r_dd_mode <= dma_cs ? RD_LIVE : RD_PULL;
         else         r_dd_mode <= RD_HOLD;
      end
   end

   assign w_dd  = (r_dd_mode == RD_LIVE) ? w_ram_q :
                  (r_dd_mode == RD_PULL) ? DD_IDLE : r_dd_last;
   assign w_din = r_din_live ? w_ram_q : r_din_last;

   assign busak_n     = r_busak_n;
   assign cpu_busrq_n = r_cpu_busrq_n;
   assign grant_len   = r_grant_len;
   assign overrun     = r_overrun;
   assign DD_DMA      = w_dd;
   assign cpu_din     = w_din;
endmodule

`default_nettype wire

// File: tb/tb_jtpopeye_busarb.sv
//------------------------------------------------------------------------------
// tb_jtpopeye_busarb: directed and random checks of the bus arbiter against a model. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_jtpopeye_busarb;
   localparam int AW   = 10;
   localparam int MAXG = 640;
   localparam int MINL = 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cpu_cen = 1'b0;
   logic          busrq_n = 1'b1;
   logic          cpu_mreq_n = 1'b1;
   logic          cpu_rd_n = 1'b1;
   logic          cpu_wr_n = 1'b1;
   logic          cpu_cs = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [7:0]    cpu_dout = 8'd0;
   logic [AW-1:0] AD_DMA = '0;
   logic          dma_cs = 1'b0;
   logic          busak_n;
   logic [7:0]    cpu_din;
   logic          cpu_busrq_n;
   logic [7:0]    DD_DMA;
   logic [15:0]   grant_len;
   logic          overrun;

   jtpopeye_busarb #(.AW(AW), .MAX_GRANT(16'(MAXG)), .MIN_LAT(MINL)) dut (
      .clk(clk), .rst_n(rst_n), .cpu_cen(cpu_cen), .busrq_n(busrq_n), .busak_n(busak_n),
      .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_cs(cpu_cs),
      .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_busrq_n(cpu_busrq_n),
      .AD_DMA(AD_DMA), .DD_DMA(DD_DMA), .dma_cs(dma_cs), .grant_len(grant_len), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int n_tot = 0;
   int n_pass = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Protocol model: who owns the bus, how long the requester has waited/held
   localparam int FREE = 0, ASKING = 1, DMA_OWNS = 2, HANDBACK = 3;
   int         phase = FREE;
   int         waited = 0;
   int         held = 0;
   logic       rq_seen = 1'b1;
   logic [7:0] mem [0:(1<<AW)-1];
   logic       e_busak_n = 1'b1, e_cpu_busrq_n = 1'b1, e_overrun = 1'b0;
   logic [7:0] e_din = 8'd0, e_dd = 8'd0;
   logic [15:0] e_len = 16'd0;

   task automatic model_edge();
      logic [7:0] old;
      if (phase == DMA_OWNS) begin
         if (rst_n) e_dd = dma_cs ? mem[AD_DMA] : 8'hFF;
      end else begin
         old = mem[cpu_addr];
         if (cpu_cen && cpu_cs && !cpu_mreq_n && !cpu_wr_n) mem[cpu_addr] = cpu_dout;
         if (rst_n && cpu_cen && cpu_cs && !cpu_rd_n) e_din = old;
      end
      if (!rst_n) begin
         phase = FREE; waited = 0; held = 0; rq_seen = 1'b1;
         e_busak_n = 1'b1; e_cpu_busrq_n = 1'b1; e_overrun = 1'b0;
         e_din = 8'd0; e_dd = 8'd0; e_len = 16'd0;
         return;
      end
      if (cpu_cen) begin
         if (phase == FREE) begin
            if (!rq_seen) begin phase = ASKING; waited = 0; e_cpu_busrq_n = 1'b0; end
         end else if (phase == ASKING) begin
            waited++;
            if (rq_seen) begin phase = FREE; e_cpu_busrq_n = 1'b1; end
            else if (waited >= MINL && cpu_mreq_n) begin phase = DMA_OWNS; held = 0; e_busak_n = 1'b0; end
         end else if (phase == DMA_OWNS) begin
            if (held < 65535) held++;
            if (held >= MAXG) e_overrun = 1'b1;
            if (rq_seen) phase = HANDBACK;
         end else begin
            e_busak_n = 1'b1; e_cpu_busrq_n = 1'b1; e_len = 16'(held); phase = FREE;
         end
      end
      rq_seen = busrq_n;
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("busak_n", 16'(busak_n), 16'(e_busak_n));
         chk("cpu_busrq_n", 16'(cpu_busrq_n), 16'(e_cpu_busrq_n));
         chk("overrun", 16'(overrun), 16'(e_overrun));
         chk("grant_len", grant_len, e_len);
         chk("DD_DMA", 16'(DD_DMA), 16'(e_dd));
         chk("cpu_din", 16'(cpu_din), 16'(e_din));
      end
   end

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         cpu_cen = 1'b1; step();
         cpu_cen = 1'b0; step();
      end
   endtask

   task automatic get_grant(output int lat);
      busrq_n = 1'b0; step();
      lat = 0;
      while (busak_n !== 1'b0 && lat < 20) begin ticks(1); lat++; end
   endtask

   task automatic drop_grant(output int lat);
      busrq_n = 1'b1; step();
      lat = 0;
      while (busak_n !== 1'b1 && lat < 20) begin ticks(1); lat++; end
   endtask

   task automatic cpu_access(input logic wr, input logic [AW-1:0] a, input logic [7:0] d);
      cpu_cs = 1'b1; cpu_mreq_n = 1'b0; cpu_addr = a; cpu_dout = d;
      cpu_wr_n = !wr; cpu_rd_n = wr; cpu_cen = 1'b1;
      step();
      cpu_cs = 1'b0; cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1; cpu_rd_n = 1'b1; cpu_cen = 1'b0;
   endtask

   int lat;

   initial begin
      repeat (3) step();
      chk_on = 1'b1;
      rst_n = 1'b1; step();
      chk("reset busak_n", 16'(busak_n), 16'h1);
      chk("reset cpu_busrq_n", 16'(cpu_busrq_n), 16'h1);
      chk("reset DD_DMA", 16'(DD_DMA), 16'h0);
      chk("reset grant_len", grant_len, 16'h0);
      chk("reset overrun", 16'(overrun), 16'h0);

      // Fill the RAM so every later read has a known value
      cpu_cs = 1'b1; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0; cpu_cen = 1'b1;
      for (int i = 0; i < (1<<AW); i++) begin
         cpu_addr = AW'(i); cpu_dout = 8'($urandom); step();
      end
      cpu_cs = 1'b0; cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1; cpu_cen = 1'b0; step();

      // Basic grant latency and length
      get_grant(lat);
      chk("grant latency", 16'(lat), 16'd2);
      ticks(5);
      drop_grant(lat);
      chk("release latency", 16'(lat), 16'd2);
      chk("grant_len hold5", grant_len, 16'd6);

      // Z80 memory cycle open during PEND delays the grant
      cpu_mreq_n = 1'b0; busrq_n = 1'b0; step();
      for (int i = 0; i < 5; i++) begin
         ticks(1);
         chk("mreq hold busak_n", 16'(busak_n), 16'h1);
      end
      chk("mreq hold cpu_busrq_n", 16'(cpu_busrq_n), 16'h0);
      cpu_mreq_n = 1'b1; ticks(1);
      chk("grant after mreq", 16'(busak_n), 16'h0);
      drop_grant(lat);

      // Z80 write then DMA read; a write during the grant is dropped
      cpu_access(1'b1, 10'h123, 8'hA5);
      get_grant(lat);
      AD_DMA = 10'h123; dma_cs = 1'b1; step();
      chk("DMA read A5", 16'(DD_DMA), 16'h00A5);
      dma_cs = 1'b0; step();
      chk("DMA pull-up", 16'(DD_DMA), 16'h00FF);
      cpu_access(1'b1, 10'h123, 8'h00);
      dma_cs = 1'b1; step();
      chk("dropped write", 16'(DD_DMA), 16'h00A5);
      dma_cs = 1'b0;
      drop_grant(lat);
      cpu_access(1'b0, 10'h123, 8'h00);
      chk("cpu read A5", 16'(cpu_din), 16'h00A5);

      // Withdrawal during PEND, once with the Z80 busy and once on the qualifying tick
      for (int k = 0; k < 2; k++) begin
         cpu_mreq_n = 1'b0; busrq_n = 1'b0; step();
         ticks(1);
         chk("withdraw pend", 16'(cpu_busrq_n), 16'h0);
         cpu_mreq_n = (k == 1); busrq_n = 1'b1; step();
         ticks(1);
         chk("withdraw busak_n", 16'(busak_n), 16'h1);
         chk("withdraw cpu_busrq_n", 16'(cpu_busrq_n), 16'h1);
         cpu_mreq_n = 1'b1; ticks(1);
         chk("withdraw stays idle", 16'(cpu_busrq_n), 16'h1);
      end

      // New request arriving while in RELEASE waits for IDLE
      get_grant(lat);
      busrq_n = 1'b1; step(); ticks(1);
      busrq_n = 1'b0; step(); ticks(1);
      chk("rel+req busak_n", 16'(busak_n), 16'h1);
      chk("rel+req cpu_busrq_n", 16'(cpu_busrq_n), 16'h1);
      ticks(1);
      chk("req after idle", 16'(cpu_busrq_n), 16'h0);
      ticks(1);
      chk("regrant", 16'(busak_n), 16'h0);
      drop_grant(lat);

      // Overrun boundary: one tick short, then past the limit, then reset mid-grant
      get_grant(lat);
      ticks(MAXG - 2);
      drop_grant(lat);
      chk("no overrun at MAX-1", 16'(overrun), 16'h0);
      chk("grant_len MAX-1", grant_len, 16'(MAXG - 1));
      get_grant(lat);
      ticks(MAXG + 3);
      chk("overrun set", 16'(overrun), 16'h1);
      drop_grant(lat);
      chk("overrun sticky", 16'(overrun), 16'h1);
      chk("grant_len long", grant_len, 16'(MAXG + 4));
      get_grant(lat);
      ticks(3);
      rst_n = 1'b0; step();
      chk("rst busak_n", 16'(busak_n), 16'h1);
      chk("rst overrun", 16'(overrun), 16'h0);
      rst_n = 1'b1; busrq_n = 1'b1; step();

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         int op;
         cpu_cen = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 15) == 0) busrq_n = ~busrq_n;
         op = $urandom_range(0, 3);
         cpu_mreq_n = (op == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
         cpu_rd_n = (op != 1);
         cpu_wr_n = (op != 2);
         cpu_cs = ($urandom_range(0, 3) != 0);
         cpu_addr = 10'h120 + AW'($urandom_range(0, 7));
         cpu_dout = 8'($urandom);
         AD_DMA = 10'h120 + AW'($urandom_range(0, 7));
         dma_cs = $urandom_range(0, 1);
         rst_n = ($urandom_range(0, 999) != 0);
         step();
      end
      rst_n = 1'b1; step();
      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

`default_nettype wire
